data_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the MEM pipeline stage (`EX_MEM` outputs) and a slow backing data memory with a request/acknowledge handshake. It replaces the zero-latency `Memory` instance on the data path. While a miss or write is outstanding it raises `stall_o` so the CPU freezes PC and all pipeline registers. Lines are one 32-bit word each.

---
 rtl/data_cache.sv | 165 ++++++++++++++++
 tb/tb_data_cache.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a stalling
// request/ack backing-memory port. Define DCACHE_PERF_CNT_EN to add hit/miss counters.
module data_cache #(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 32 - 2 - INDEX_W
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

    state_e             state_q, state_d;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES];

    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;

    logic [INDEX_W-1:0] req_idx, lat_idx;
    logic [TAG_W-1:0]   req_tag, lat_tag;
    logic               hit, lat_hit;
    logic               fill_en, wr_upd;
    logic               unused_addr_bits;

    assign req_idx = addr_i[INDEX_W+1:2];
    assign req_tag = addr_i[31:INDEX_W+2];
    // The latched memory address doubles as the line pointer during FILL/WRITE.
    assign lat_idx = mem_addr_q[INDEX_W+1:2];
    assign lat_tag = mem_addr_q[31:INDEX_W+2];
    assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

    assign unused_addr_bits = ^addr_i[1:0];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        stall_o     = 1'b0;
        rdata_o     = '0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_en     = 1'b0;
        wr_upd      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (we_i || !hit) begin
                        stall_o    = 1'b1;
                        mem_req_d  = 1'b1;
                        mem_we_d   = we_i;
                        mem_addr_d = {addr_i[31:2], 2'b00};
                        if (we_i) mem_wdata_d = wdata_i;
                        state_d    = we_i ? WRITE : FILL;
                    end else begin
                        rdata_o = data_q[req_idx];
                    end
                end
            end
            FILL: begin
                if (mem_ack_i) begin
                    rdata_o   = mem_rdata_i;
                    fill_en   = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            WRITE: begin
                if (mem_ack_i) begin
                    wr_upd    = lat_hit;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if (fill_en) valid_q[lat_idx] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays are deliberately not reset; the valid bits alone qualify them.
    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            tag_q[lat_idx]  <= lat_tag;
            data_q[lat_idx] <= mem_rdata_i;
        end else if (wr_upd) begin
            data_q[lat_idx] <= mem_wdata_q;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        read_hit, read_miss;

    assign read_hit  = (state_q == IDLE) && req_i && !we_i && hit;
    assign read_miss = (state_q == IDLE) && req_i && !we_i && !hit;

    // Saturating counters: they stick at all-ones rather than wrapping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (read_hit && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (read_miss && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: a line-level reference model predicts each
// access; a monitor checks CPU-side completions and a responder checks memory requests.
module tb_data_cache;

    localparam int INDEX_W = 4;
    localparam int LINES   = 1 << INDEX_W;
    localparam int TAG_W   = 32 - 2 - INDEX_W;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          k;
    } mem_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] rdata;
        logic        need_mem;
        int          stall;
    } sb_t;

    logic        clk;
    logic        rst_i;
    logic        req_i, we_i;
    logic [31:0] addr_i, wdata_i, rdata_o;
    logic        stall_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        mem_ack_i;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    data_cache #(.INDEX_W(INDEX_W)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .stall_o    (stall_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ack_i  (mem_ack_i)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    mem_exp_t mem_exp_q[$];
    sb_t      sb_q[$];

    // Reference model: which word each line holds, plus the backing memory image.
    bit          m_valid [LINES];
    logic [31:0] m_line  [LINES];
    logic [31:0] m_data  [LINES];
    logic [31:0] bmem    [logic [31:0]];
    int          m_hits, m_misses;

    bit mon_en  = 1'b0;
    bit resp_en = 1'b1;
    int stray_req = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Predict, enqueue expectations, then drive one access until it completes.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd, input int k);
        logic [31:0] word;
        int          idx;
        bit          miss;
        logic [31:0] rd;
        int          n;
        word = {addr[31:2], 2'b00};
        idx  = int'(word[INDEX_W+1:2]);
        miss = !(m_valid[idx] && m_line[idx] == word);
        rd   = '0;
        if (we) begin
            bmem[word] = wd;
            if (!miss) m_data[idx] = wd;
        end else if (miss) begin
            rd           = mem_rd(word);
            m_valid[idx] = 1'b1;
            m_line[idx]  = word;
            m_data[idx]  = rd;
            m_misses++;
        end else begin
            rd = m_data[idx];
            m_hits++;
        end
        if (we || miss) mem_exp_q.push_back('{we: we, addr: word, wdata: wd, k: k});
        sb_q.push_back('{we: we, rdata: rd, need_mem: (we || miss), stall: (we || miss) ? k + 1 : 0});

        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        wdata_i = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall_o && n < 100);
        if (stall_o) begin
            check("access_timeout", {31'd0, stall_o}, 32'd0);
            finish_run();
        end
        @(posedge clk);
        #1;
        req_i = 1'b0;
        we_i  = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the CPU side sees a completed access.
    initial begin
        bit  saw_mem;
        int  stall_cnt;
        sb_t s;
        saw_mem   = 1'b0;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                saw_mem   = 1'b0;
                stall_cnt = 0;
            end else begin
                if (mem_req_o) saw_mem = 1'b1;
                if (req_i && stall_o) stall_cnt++;
                if (req_i && !stall_o) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion: got completion at %h, required none", addr_i);
                    end else begin
                        s = sb_q.pop_front();
                        if (!s.we) check("rdata", rdata_o, s.rdata);
                        check("mem_access", {31'd0, saw_mem}, {31'd0, s.need_mem});
                        check("stall_cycles", stall_cnt, s.stall);
                    end
                    saw_mem   = 1'b0;
                    stall_cnt = 0;
                end
                if (!(req_i && !we_i && !stall_o)) check("rdata_zero", rdata_o, 32'd0);
            end
        end
    end

    // Responder: the backing memory; checks each request against the expected one.
    initial begin
        mem_exp_t e;
        int       stray_done;
        stray_done  = 0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (stray_done != stray_req) begin
                stray_done++;
                @(posedge clk);
                #1;
                mem_ack_i   = 1'b1;
                mem_rdata_i = $urandom;
                @(posedge clk);
                #1;
                mem_ack_i = 1'b0;
            end else if (resp_en && mem_req_o) begin
                if (mem_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem_req: got request to %h, required none", mem_addr_o);
                    e = '{we: mem_we_o, addr: mem_addr_o, wdata: mem_wdata_o, k: 1};
                end else begin
                    e = mem_exp_q.pop_front();
                    check("mem_we", {31'd0, mem_we_o}, {31'd0, e.we});
                    check("mem_addr", mem_addr_o, e.addr);
                    if (e.we) check("mem_wdata", mem_wdata_o, e.wdata);
                end
                repeat (e.k) @(posedge clk);
                #1;
                check("mem_addr_hold", mem_addr_o, e.addr);
                mem_ack_i   = 1'b1;
                mem_rdata_i = e.we ? $urandom : mem_rd(mem_addr_o);
                @(posedge clk);
                #1;
                mem_ack_i   = 1'b0;
                mem_rdata_i = $urandom;
            end
        end
    end

    initial begin
        #500000;
        check("watchdog", 32'd1, 32'd0);
        finish_run();
    end

    // Driver: directed test-plan sequence, reset abort, then random traffic.
    initial begin
        logic [TAG_W-1:0] tags [4];
        logic [31:0]      a;
        logic             w;
        tags = '{{TAG_W{1'b0}}, TAG_W'(1), TAG_W'(2), {TAG_W{1'b1}}};
        rst_i   = 1'b0;
        req_i   = 1'b0;
        we_i    = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
        model_reset();
        bmem[32'h100] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_mem_wdata", mem_wdata_o, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
`ifdef DCACHE_PERF_CNT_EN
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
`endif
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        access(1'b0, 32'h100, 32'd0, 3);
        access(1'b0, 32'h100, 32'd0, 1);
        access(1'b0, 32'h140, 32'd0, 2);
        access(1'b0, 32'h100, 32'd0, 1);
        access(1'b1, 32'h100, 32'h1234_5678, 2);
        access(1'b0, 32'h103, 32'd0, 1);
        access(1'b1, 32'h200, 32'hCAFE_F00D, 1);
        access(1'b0, 32'h200, 32'd0, 4);

        // Reset in the middle of a fill: request drops at once and no line is written.
        mon_en  = 1'b0;
        resp_en = 1'b0;
        req_i   = 1'b1;
        we_i    = 1'b0;
        addr_i  = 32'h300;
        repeat (2) @(posedge clk);
        #1;
        check("fill_req_up", {31'd0, mem_req_o}, 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        check("rst_async_req", {31'd0, mem_req_o}, 32'd0);
        req_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        model_reset();
        stray_req++;
        repeat (4) @(posedge clk);
        #1;
        check("stray_ack_req", {31'd0, mem_req_o}, 32'd0);
        check("stray_ack_stall", {31'd0, stall_o}, 32'd0);
        resp_en = 1'b1;
        mon_en  = 1'b1;

        access(1'b0, 32'h300, 32'd0, 2);
        access(1'b0, 32'h300, 32'd0, 1);
        access(1'b0, 32'h300, 32'd0, 1);
        access(1'b0, 32'h304, 32'd0, 1);
        access(1'b0, 32'h304, 32'd0, 1);
        access(1'b1, 32'h304, 32'h0BAD_F00D, 1);
`ifdef DCACHE_PERF_CNT_EN
        @(negedge clk);
        check("plan_hit_cnt", hit_cnt, 32'd3);
        check("plan_miss_cnt", miss_cnt, 32'd2);
        @(posedge clk);
        #1;
`endif

        for (int i = 0; i < 300; i++) begin
            a = {tags[$urandom_range(0, 3)], INDEX_W'($urandom_range(0, LINES - 1)), 2'($urandom_range(0, 3))};
            w = ($urandom_range(0, 3) == 0);
            access(w, a, $urandom, $urandom_range(1, 5));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        check("mem_exp_drained", mem_exp_q.size(), 32'd0);
`ifdef DCACHE_PERF_CNT_EN
        check("hit_cnt", hit_cnt, m_hits);
        check("miss_cnt", miss_cnt, m_misses);
`endif
        finish_run();
    end

endmodule
